// File: rtl/aes_mix_columns_pipe.sv
// Multi-lane pipelined AES MixColumns / InvMixColumns engine.
// The column transform is evaluated combinationally on the request and
// captured in stage 0; later stages only move the result along under a
// valid/ack handshake with full backpressure, flush and occupancy count.
module aes_mix_columns_pipe #(
    parameter int NumLanes   = 1,
    parameter int PipeStages = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              _ep_req_valid,
    output logic                              _ep_req_ack,
    input  logic [NumLanes*128+1:0]           _ep_req_0,
    output logic                              _ep_res_valid,
    input  logic                              _ep_res_ack,
    output logic [NumLanes*128:0]             _ep_res_0,
    input  logic                              _ep_flush_valid,
    output logic [$clog2(PipeStages+1)-1:0]   _ep_occ_0
);

    localparam int ResW = NumLanes * 128 + 1;
    localparam int OccW = $clog2(PipeStages + 1);

    // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (covers 01, 02, 03, 09, 0b, 0d, 0e)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // One column, row 0 in the low byte; inv selects the 0e/0b/0d/09 matrix
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [3:0] k0, k1, k2, k3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        k0 = inv ? 4'he : 4'h2;
        k1 = inv ? 4'hb : 4'h3;
        k2 = inv ? 4'hd : 4'h1;
        k3 = inv ? 4'h9 : 4'h1;
        b0 = gf_mul(a0, k0) ^ gf_mul(a1, k1) ^ gf_mul(a2, k2) ^ gf_mul(a3, k3);
        b1 = gf_mul(a1, k0) ^ gf_mul(a2, k1) ^ gf_mul(a3, k2) ^ gf_mul(a0, k3);
        b2 = gf_mul(a2, k0) ^ gf_mul(a3, k1) ^ gf_mul(a0, k2) ^ gf_mul(a1, k3);
        b3 = gf_mul(a3, k0) ^ gf_mul(a0, k1) ^ gf_mul(a1, k2) ^ gf_mul(a2, k3);
        return {b3, b2, b1, b0};
    endfunction

    logic [1:0]               op;
    logic                     op_fwd;
    logic                     op_inv;
    logic [NumLanes*128-1:0]  mixed;
    logic [ResW-1:0]          xform;

    logic [PipeStages-1:0]    vld_q;
    logic [PipeStages-1:0]    vld_d;
    logic [PipeStages-1:0]    adv;
    logic [ResW-1:0]          data_q [PipeStages];
    logic [ResW-1:0]          data_d [PipeStages];
    logic [OccW-1:0]          occ_q;
    logic [OccW-1:0]          occ_d;
    logic                     in_ready;
    logic                     req_ack;

    assign op     = _ep_req_0[1:0];
    assign op_fwd = (op == 2'b01);
    assign op_inv = (op == 2'b10);

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign mixed[128*l+32*c +: 32] = mix_column(_ep_req_0[2+128*l+32*c +: 32], op_inv);
        end
    end

    // Illegal op still produces a transaction, but with zeroed data and err set
    always_comb begin
        xform = '0;
        if (op_fwd || op_inv) begin
            xform = {mixed, 1'b0};
        end else begin
            xform = {{(NumLanes*128){1'b0}}, 1'b1};
        end
    end

    // Advance chain: a stage moves when it is valid and the one below can take it
    always_comb begin
        logic down_adv;
        logic a_k;
        adv      = '0;
        down_adv = _ep_res_ack;
        for (int k = PipeStages - 1; k >= 0; k--) begin
            a_k      = vld_q[k] && down_adv;
            adv[k]   = a_k;
            down_adv = !vld_q[k] || a_k;
        end
    end

    assign in_ready = !vld_q[0] || adv[0];
    assign req_ack  = rst_ni && _ep_req_valid && in_ready && !_ep_flush_valid;

    // Next-state of every stage; flush wins over advancement and clears data too
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        occ_d  = '0;
        if (_ep_flush_valid) begin
            vld_d = '0;
            for (int k = 0; k < PipeStages; k++) begin
                data_d[k] = '0;
            end
        end else begin
            for (int k = PipeStages - 1; k >= 1; k--) begin
                if (adv[k-1]) begin
                    vld_d[k]  = 1'b1;
                    data_d[k] = data_q[k-1];
                end else if (adv[k]) begin
                    vld_d[k]  = 1'b0;
                    data_d[k] = '0;
                end
            end
            if (req_ack) begin
                vld_d[0]  = 1'b1;
                data_d[0] = xform;
            end else if (adv[0]) begin
                vld_d[0]  = 1'b0;
                data_d[0] = '0;
            end
        end
        for (int k = 0; k < PipeStages; k++) begin
            occ_d = occ_d + OccW'(vld_d[k]);
        end
    end

    // Stage registers and occupancy; reset discards everything in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < PipeStages; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            for (int k = 0; k < PipeStages; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign _ep_req_ack   = req_ack;
    assign _ep_res_valid = vld_q[PipeStages-1];
    assign _ep_res_0     = data_q[PipeStages-1];
    assign _ep_occ_0     = occ_q;

endmodule

// File: tb/tb_aes_mix_columns_pipe.sv
// Directed bench for aes_mix_columns_pipe: a single-lane two-stage instance
// for the transform vectors and a two-lane three-stage instance for
// streaming, backpressure, illegal op, flush and mid-stream reset.
module tb_aes_mix_columns_pipe;

    localparam int LA = 1;
    localparam int PA = 2;
    localparam int LB = 2;
    localparam int PB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              a_rst_n, a_req_valid, a_req_ack, a_res_valid, a_res_ack, a_flush;
    logic [LA*128+1:0] a_req;
    logic [LA*128:0]   a_res;
    logic [1:0]        a_occ;

    logic              b_rst_n, b_req_valid, b_req_ack, b_res_valid, b_res_ack, b_flush;
    logic [LB*128+1:0] b_req;
    logic [LB*128:0]   b_res;
    logic [1:0]        b_occ;

    aes_mix_columns_pipe #(.NumLanes(LA), .PipeStages(PA)) u_a (
        .clk_i(clk), .rst_ni(a_rst_n),
        ._ep_req_valid(a_req_valid), ._ep_req_ack(a_req_ack), ._ep_req_0(a_req),
        ._ep_res_valid(a_res_valid), ._ep_res_ack(a_res_ack), ._ep_res_0(a_res),
        ._ep_flush_valid(a_flush), ._ep_occ_0(a_occ)
    );

    aes_mix_columns_pipe #(.NumLanes(LB), .PipeStages(PB)) u_b (
        .clk_i(clk), .rst_ni(b_rst_n),
        ._ep_req_valid(b_req_valid), ._ep_req_ack(b_req_ack), ._ep_req_0(b_req),
        ._ep_res_valid(b_res_valid), ._ep_res_ack(b_res_ack), ._ep_res_0(b_res),
        ._ep_flush_valid(b_flush), ._ep_occ_0(b_occ)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check_vec(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [127:0] st;
        logic [127:0] exp;
        logic         err;
    } vec_t;

    vec_t vt[10];

    logic [31:0] pin[6];
    logic [31:0] pout[6];
    logic [LB*128+1:0] b_tx[8];
    logic [LB*128:0]   b_exp[8];

    // Send one request to instance B and check result and latency
    task automatic b_single(input string name, input logic [1:0] op,
                            input logic [255:0] lanes, input logic [256:0] exp);
        int k;
        @(negedge clk);
        b_req       = {lanes, op};
        b_req_valid = 1'b1;
        #1;
        check_int({name, "_ack"}, int'(b_req_ack), 1);
        @(negedge clk);
        b_req_valid = 1'b0;
        k = 0;
        while (k < 10 && !b_res_valid) begin
            @(negedge clk);
            k++;
        end
        check_int({name, "_latency"}, k, PB - 1);
        check_vec({name, "_res"}, 257'(b_res), exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx, rx, occ_m, cyc;
        logic prev_hold, stall_seen, pass_seen, consumed, exp_ack;
        logic [LB*128:0] prev_res;
        logic [127:0] l0, l1, e0, e1;
        int idx;

        vt[0] = '{2'b01, {96'h0, 32'h455313db}, {96'h0, 32'hbca14d8e}, 1'b0};
        vt[1] = '{2'b01, {96'h0, 32'h5c220af2}, {96'h0, 32'h9d58dc9f}, 1'b0};
        vt[2] = '{2'b10, {96'h0, 32'hbca14d8e}, {96'h0, 32'h455313db}, 1'b0};
        vt[3] = '{2'b01, {4{32'h01010101}}, {4{32'h01010101}}, 1'b0};
        vt[4] = '{2'b10, {4{32'h01010101}}, {4{32'h01010101}}, 1'b0};
        vt[5] = '{2'b01, {32'h01010101, 32'hc6c6c6c6, 32'hd5d4d4d4, 32'h4c31262d},
                         {32'h01010101, 32'hc6c6c6c6, 32'hd6d7d5d5, 32'hf8bd7e4d}, 1'b0};
        vt[6] = '{2'b10, {32'h01010101, 32'hc6c6c6c6, 32'hd6d7d5d5, 32'hf8bd7e4d},
                         {32'h01010101, 32'hc6c6c6c6, 32'hd5d4d4d4, 32'h4c31262d}, 1'b0};
        vt[7] = '{2'b11, 128'h0123456789abcdeffedcba9876543210, 128'h0, 1'b1};
        vt[8] = '{2'b00, {4{32'h455313db}}, 128'h0, 1'b1};
        vt[9] = '{2'b01, {32'h5c220af2, 32'h0, 32'h455313db, 32'h0},
                         {32'h9d58dc9f, 32'h0, 32'hbca14d8e, 32'h0}, 1'b0};

        pin  = '{32'h455313db, 32'h5c220af2, 32'hc6c6c6c6, 32'h01010101, 32'hd5d4d4d4, 32'h4c31262d};
        pout = '{32'hbca14d8e, 32'h9d58dc9f, 32'hc6c6c6c6, 32'h01010101, 32'hd6d7d5d5, 32'hf8bd7e4d};

        for (int n = 0; n < 8; n++) begin
            for (int c = 0; c < 4; c++) begin
                idx = (n + c) % 6;
                l0[32*c +: 32] = (n < 6) ? pin[idx]  : pout[idx];
                e0[32*c +: 32] = (n < 6) ? pout[idx] : pin[idx];
                idx = (n + c + 3) % 6;
                l1[32*c +: 32] = (n < 6) ? pin[idx]  : pout[idx];
                e1[32*c +: 32] = (n < 6) ? pout[idx] : pin[idx];
            end
            b_tx[n]  = {l1, l0, (n < 6) ? 2'b01 : 2'b10};
            b_exp[n] = {e1, e0, 1'b0};
        end

        a_rst_n = 1'b0; a_req_valid = 1'b1; a_req = {vt[0].st, vt[0].op};
        a_res_ack = 1'b1; a_flush = 1'b0;
        b_rst_n = 1'b0; b_req_valid = 1'b1; b_req = b_tx[0];
        b_res_ack = 1'b1; b_flush = 1'b0;

        // reset behaviour
        repeat (2) @(negedge clk);
        #1;
        check_int("a_rst_ack", int'(a_req_ack), 0);
        check_int("b_rst_ack", int'(b_req_ack), 0);
        check_int("a_rst_valid", int'(a_res_valid), 0);
        check_vec("a_rst_res", 257'(a_res), 257'h0);
        check_int("a_rst_occ", int'(a_occ), 0);
        check_int("b_rst_valid", int'(b_res_valid), 0);
        check_vec("b_rst_res", 257'(b_res), 257'h0);
        check_int("b_rst_occ", int'(b_occ), 0);
        @(negedge clk);
        a_rst_n = 1'b1; a_req_valid = 1'b0;
        b_rst_n = 1'b1; b_req_valid = 1'b0;

        // transform vectors on the single-lane two-stage instance
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_req       = {vt[i].st, vt[i].op};
            a_req_valid = 1'b1;
            #1;
            check_int("a_ack", int'(a_req_ack), 1);
            @(negedge clk);
            a_req_valid = 1'b0;
            check_int("a_lat1_valid", int'(a_res_valid), 0);
            @(negedge clk);
            check_int("a_lat2_valid", int'(a_res_valid), 1);
            check_vec("a_res", 257'(a_res), 257'({vt[i].exp, vt[i].err}));
        end

        // streaming with a backpressure window on the two-lane three-stage instance
        tx = 0; rx = 0; occ_m = 0; cyc = 0;
        prev_hold = 1'b0; stall_seen = 1'b0; pass_seen = 1'b0; prev_res = '0;
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            b_res_ack   = !(cyc >= 4 && cyc <= 7);
            b_req_valid = (tx < 8);
            b_req       = (tx < 8) ? b_tx[tx] : '0;
            #1;
            check_int("b_occ", int'(b_occ), occ_m);
            exp_ack = b_req_valid && (occ_m < PB || b_res_ack);
            check_int("b_ack", int'(b_req_ack), int'(exp_ack));
            if (prev_hold) begin
                check_int("b_hold_valid", int'(b_res_valid), 1);
                check_vec("b_hold_data", 257'(b_res), 257'(prev_res));
            end
            if (b_occ == 2'd3 && b_req_valid && !b_req_ack) stall_seen = 1'b1;
            if (b_occ == 2'd3 && b_req_ack && b_res_valid && b_res_ack) pass_seen = 1'b1;
            consumed = b_res_valid && b_res_ack;
            if (consumed) begin
                if (rx < 8) check_vec("b_stream_res", 257'(b_res), 257'(b_exp[rx]));
                rx++;
            end
            if (b_req_ack) tx++;
            occ_m = occ_m + int'(b_req_ack) - int'(consumed);
            prev_hold = b_res_valid && !b_res_ack;
            prev_res  = b_res;
            cyc++;
        end
        b_req_valid = 1'b0;
        b_res_ack   = 1'b1;
        check_int("b_stream_count", rx, 8);
        check_int("b_stall_seen", int'(stall_seen), 1);
        check_int("b_passthru_seen", int'(pass_seen), 1);
        @(negedge clk);
        check_int("b_drained_occ", int'(b_occ), 0);
        check_int("b_drained_valid", int'(b_res_valid), 0);

        // illegal op then a legal one
        b_single("b_illegal", 2'b11, {8{32'hdeadbeef}}, 257'h1);
        b_single("b_legal", 2'b01,
                 {32'h0, 32'h5c220af2, 64'h0, 96'h0, 32'h455313db},
                 {32'h0, 32'h9d58dc9f, 64'h0, 96'h0, 32'hbca14d8e, 1'b0});

        // flush with two in flight and a simultaneous request
        @(negedge clk);
        b_res_ack = 1'b0;
        b_req = b_tx[0]; b_req_valid = 1'b1;
        @(negedge clk);
        b_req = b_tx[1];
        @(negedge clk);
        check_int("b_flush_pre_occ", int'(b_occ), 2);
        b_req = b_tx[2]; b_flush = 1'b1;
        #1;
        check_int("b_flush_ack", int'(b_req_ack), 0);
        @(negedge clk);
        b_flush = 1'b0; b_req_valid = 1'b0; b_res_ack = 1'b1;
        check_int("b_flush_occ", int'(b_occ), 0);
        check_int("b_flush_valid", int'(b_res_valid), 0);
        check_vec("b_flush_res", 257'(b_res), 257'h0);

        // reset for one edge in the middle of a stream
        @(negedge clk);
        b_req = b_tx[3]; b_req_valid = 1'b1;
        @(negedge clk);
        b_req = b_tx[4];
        @(negedge clk);
        b_rst_n = 1'b0; b_req = b_tx[5];
        #1;
        check_int("b_midrst_ack", int'(b_req_ack), 0);
        @(negedge clk);
        b_rst_n = 1'b1; b_req_valid = 1'b0;
        check_int("b_midrst_occ", int'(b_occ), 0);
        check_int("b_midrst_valid", int'(b_res_valid), 0);
        check_vec("b_midrst_res", 257'(b_res), 257'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns_pipe.md
Name: aes_mix_columns_pipe

Overview:
- Multi-lane, pipelined AES MixColumns/InvMixColumns engine with valid/ack handshakes on both sides.
- Successor to the purely combinational mix-columns wrapper. Adds:
  - NumLanes parallel 128-bit states per transaction
  - a configurable pipeline depth with backpressure
  - synchronous flush
  - an error flag for illegal op encodings
  - an occupancy count
- Sits between round-key/sub-bytes stages of an iterative cipher datapath, or serves as a standalone throughput test block.

Parameters:
- NumLanes, 1: number of 128-bit AES states processed per transaction (1..4).
- PipeStages, 2: number of register stages between request acceptance and result (1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- _ep_req_valid  in  1  request valid
- _ep_req_ack  out  1  request accepted this cycle
- _ep_req_0  in  NumLanes*128+2  [1:0] op (2'b01 forward, 2'b10 inverse); lane i state at [2+128*i +:128]
- _ep_res_valid  out  1  result valid
- _ep_res_ack  in  1  result consumed
- _ep_res_0  out  NumLanes*128+1  [0] err; lane i result at [1+128*i +:128]
- _ep_flush_valid  in  1  synchronous pipeline flush
- _ep_occ_0  out  $clog2(PipeStages+1)  number of valid stages

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values (sampled on clk_i edge with rst_ni=0): all stage valid bits 0, all stage data 0. Outputs after reset:
  - _ep_res_valid=0, _ep_res_0=0, _ep_occ_0=0.
  - _ep_req_ack=0 while rst_ni=0.
- State layout: byte j=4*col+row at bits [8j+:8]. Column c occupies [32c+:32], with row 0 in the low byte.
- Forward transform per column, a0..a3 to b0..b3 in GF(2^8), poly 0x11B:
  - b_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
- Inverse transform: coefficients 0e, 0b, 0d, 09 in the same rotation.
- All lanes use the single op field.
- Illegal op (2'b00 or 2'b11):
  - transaction still flows through the pipeline;
  - all lane results forced to 0, err=1.
  - Legal op gives err=0.
- Transform is computed combinationally ahead of stage 0. Stages 1..PipeStages-1 carry data unchanged.
- Stage k advances when it is valid and (stage k+1 is empty or stage k+1 advances). The last stage advances when _ep_res_ack=1.
- Ready: in_ready = !stage0_valid || stage0_advance.
- _ep_req_ack = _ep_req_valid && in_ready && !_ep_flush_valid. It is combinational and may depend on _ep_res_ack.
- Latency: with no backpressure, a result appears on _ep_res_valid exactly PipeStages cycles after the ack cycle. Throughput is one transaction per cycle.
- Result stability: _ep_res_valid and _ep_res_0 reflect the last stage. They hold stable while _ep_res_valid=1 and _ep_res_ack=0. Results are never dropped or duplicated, and order is preserved.
- Full pipeline: when full with _ep_res_ack=0, _ep_req_ack=0. When full with _ep_res_ack=1, a new request is accepted in the same cycle (no bubble).
- Empty pipeline: _ep_res_valid=0. _ep_res_ack is ignored.
- _ep_occ_0 = count of valid stage bits, updated registered. It reaches PipeStages when full.
- Flush:
  - _ep_flush_valid=1 clears all valid bits and data next edge, giving occ=0 and res_0=0.
  - A result acked in the flush cycle counts as consumed.
  - No request is accepted in the flush cycle.
  - Flush has priority over advancement.
- Reset mid-operation: identical to flush. All in-flight transactions are discarded.
- _ep_res_ack with _ep_res_valid=0: no effect.

Test Plan:
- Single column vector, NumLanes=1, PipeStages=2, op=01. Column 0 word 0x455313db, others 0 → after 2 cycles res lane column 0 = 0xbca14d8e, other columns 0, err=0. Same with 0x5c220af2 → 0x9d58dc9f.
- Inverse round trip: op=10 on state 0xbca14d8e (col0) → 0x455313db. A column of 0x01010101 maps to itself both directions.
- Streaming with backpressure, NumLanes=2, PipeStages=3: 8 back-to-back requests, _ep_res_ack low for cycles 4-7.
  - _ep_req_ack drops once occ=3.
  - Outputs hold stable while stalled.
  - All 8 results arrive in order, with no loss or duplication.
- Full-pipe pass-through: pipeline full, _ep_res_ack=1 and _ep_req_valid=1 in the same cycle → _ep_req_ack=1, occ stays 3.
- Illegal op 2'b11 with arbitrary data → result data all 0, err=1. The next legal transaction has err=0.
- Flush with occ=2 plus simultaneous request → _ep_req_ack=0, next cycle occ=0 and _ep_res_valid=0. Assert rst_ni=0 for one edge mid-stream → all outputs 0 the next cycle.
